mont_inv_ctrl: RTL and testbench

- Fermat-inversion sequencer for the Ed448 field, p = 2^448 - 2^224 - 1.
- Computes a^(p-2) mod p in the Montgomery domain by left-to-right square-and-multiply over the fixed exponent INV_EXP = MODULUS - 2.
- Does not multiply by itself: it drives an external shared Montgomery multiplier through a req/ack handshake.
- Used by the point-encoding path to convert projective coordinates to affine (Z^-1).

---
 rtl/mont_inv_ctrl_pkg.sv | 29 ++
 rtl/mont_inv_ctrl.sv | 150 +++++++++++++++
 tb/tb_mont_inv_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_inv_ctrl_pkg.sv
// Shared Ed448 field parameters and inversion-sequencer types.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package mont_inv_ctrl_pkg;

  localparam int DATA_WIDTH = 448;
  localparam int IDX_WIDTH  = 9;

  // p = 2^448 - 2^224 - 1: every bit set except bit 224.
  localparam logic [DATA_WIDTH-1:0] MODULUS = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  // Fermat exponent p - 2. Bits 224 and 1 are clear; all other bits are set.
  localparam logic [DATA_WIDTH-1:0] INV_EXP = MODULUS - DATA_WIDTH'(2);

  // Montgomery one: R mod p = 2^448 mod p = 2^224 + 1.
  localparam logic [DATA_WIDTH-1:0] R_MOD_P = {{223{1'b0}}, 1'b1, {223{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQR  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } inv_state_t;

  function automatic logic exp_bit(input logic [IDX_WIDTH-1:0] i);
    return INV_EXP[i];
  endfunction

endpackage

// File: rtl/mont_inv_ctrl.sv
// Fermat inversion a^(p-2) mod p for Ed448 in the Montgomery domain, using an external multiplier.
// Latency: 892 multiplier operations; done in cycle 892*(L+1)+1 after start for a fixed multiplier delay L.
// Backpressure: mul_req and operands are held until mul_ack; start is ignored unless idle.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, a_in       one-cycle start pulse and operand (a*R mod p), sampled only in IDLE
//   busy, done        busy while multiplying; done pulses for one cycle when result is valid
//   result            a^-1 in Montgomery form, held until the next completion
//   mul_req/a/b       request and operands to the shared Montgomery multiplier
//   mul_ack/res       one-cycle acknowledge with product A*B*R^-1 mod p
//   zero_err          only with MONT_INV_ZERO_DET_EN: sticky flag for a zero operand
//
// Build option: define MONT_INV_ZERO_DET_EN to short-circuit a zero operand without
// touching the multiplier and raise zero_err.
module mont_inv_ctrl
  import mont_inv_ctrl_pkg::*;
#(
  parameter int EXP_MSB = DATA_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  mul_req,
  output logic [DATA_WIDTH-1:0] mul_a,
  output logic [DATA_WIDTH-1:0] mul_b,
  input  logic                  mul_ack,
`ifdef MONT_INV_ZERO_DET_EN
  output logic                  zero_err,
`endif
  input  logic [DATA_WIDTH-1:0] mul_res
);

  inv_state_t            state, state_d;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] acc, acc_d;
  logic [IDX_WIDTH-1:0]  idx, idx_d;
  logic                  accept;
  logic                  zero_pend;

  assign accept = (state == IDLE) && start;

`ifdef MONT_INV_ZERO_DET_EN
  // A zero operand is flagged at start and resolved in the first busy cycle,
  // so DONE lands in cycle 2 without ever raising mul_req.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_pend <= 1'b0;
      zero_err  <= 1'b0;
    end else if (accept) begin
      zero_pend <= (a_in == '0);
      zero_err  <= (a_in == '0);
    end else if (state == DONE) begin
      zero_pend <= 1'b0;
    end
  end
`else
  assign zero_pend = 1'b0;
`endif

  // Outputs are decoded from state so an async reset drops mul_req, busy and
  // the operands immediately, abandoning any in-flight request.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    idx_d   = idx;
    busy    = 1'b0;
    done    = 1'b0;
    mul_req = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    case (state)
      IDLE: begin
        if (start) begin
          // Top exponent bit is 1, so the accumulator starts as a itself.
          acc_d   = a_in;
          idx_d   = IDX_WIDTH'(EXP_MSB - 1);
          state_d = SQR;
        end
      end
      SQR: begin
        busy = 1'b1;
        if (zero_pend) begin
          state_d = DONE;
        end else begin
          mul_req = 1'b1;
          mul_a   = acc;
          mul_b   = acc;
          if (mul_ack) begin
            acc_d = mul_res;
            if (exp_bit(idx)) begin
              state_d = MUL;
            end else if (idx == '0) begin
              state_d = DONE;
            end else begin
              idx_d = idx - 1'b1;
            end
          end
        end
      end
      MUL: begin
        busy    = 1'b1;
        mul_req = 1'b1;
        mul_a   = acc;
        mul_b   = a_reg;
        if (mul_ack) begin
          acc_d = mul_res;
          if (idx == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx - 1'b1;
            state_d = SQR;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_reg  <= '0;
      acc    <= '0;
      idx    <= '0;
      result <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      idx   <= idx_d;
      if (accept) begin
        a_reg <= a_in;
      end
      // Capture the final product on entry to DONE so result is already
      // valid in the cycle done is asserted.
      if ((state != DONE) && (state_d == DONE)) begin
        result <= acc_d;
      end
    end
  end

endmodule

// File: tb/tb_mont_inv_ctrl.sv
// Directed bench for mont_inv_ctrl with a behavioural Montgomery multiplier of programmable delay.
// Latency: expected done cycles are derived from 892 operations of (L+1) cycles each.
// Backpressure: the multiplier model holds each request for L cycles before acknowledging.
module tb_mont_inv_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [447:0] a_in;
  logic         busy, done, mul_req, mul_ack;
  logic [447:0] result, mul_a, mul_b, mul_res;
`ifdef MONT_INV_ZERO_DET_EN
  logic         zero_err;
`endif

  mont_inv_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_ack (mul_ack),
`ifdef MONT_INV_ZERO_DET_EN
    .zero_err(zero_err),
`endif
    .mul_res (mul_res)
  );

  always #5 clk = ~clk;

  // Field constants computed locally by the bench.
  logic [448:0] p_w;
  logic [447:0] p, rinv, r_one, mont_two, mont_half;

  int checks = 0;
  int errors = 0;

  int fix_l;      // multiplier delay; negative selects random 0..7 per request
  int acks, reqs, viol;
  bit spur;

  task automatic chk(input string tag, input logic [447:0] got, input logic [447:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [447:0] mod_mul(input logic [447:0] x, input logic [447:0] y);
    logic [895:0] t;
    t = {448'd0, x} * {448'd0, y};
    t = t % {448'd0, p};
    return t[447:0];
  endfunction

  function automatic logic [447:0] mont(input logic [447:0] x, input logic [447:0] y);
    return mod_mul(mod_mul(x, y), rinv);
  endfunction

  function automatic logic [447:0] rand448();
    logic [447:0] r;
    for (int i = 0; i < 14; i++) r[i*32 +: 32] = $urandom;
    if (r >= p) r = r - p;
    if (r == '0) r = 448'd1;
    return r;
  endfunction

  // Behavioural multiplier: one ack per request, L cycles after it rises,
  // and operand-stability monitoring while the request is pending.
  initial begin : mult_model
    bit           active;
    int           cnt;
    logic [447:0] ha, hb;
    active  = 1'b0;
    cnt     = 0;
    ha      = '0;
    hb      = '0;
    mul_ack = 1'b0;
    mul_res = '0;
    forever begin
      @(negedge clk);
      if (mul_ack) active = 1'b0;
      mul_ack = 1'b0;
      if (!mul_req) begin
        active = 1'b0;
        if (spur) begin
          spur    = 1'b0;
          mul_ack = 1'b1;
          mul_res = rand448();
        end
      end else begin
        if (!active) begin
          active = 1'b1;
          reqs++;
          cnt = (fix_l < 0) ? int'($urandom_range(0, 7)) : fix_l;
          ha  = mul_a;
          hb  = mul_b;
        end else if (mul_a !== ha || mul_b !== hb) begin
          viol++;
        end
        if (cnt == 0) begin
          mul_ack = 1'b1;
          mul_res = mont(mul_a, mul_b);
          acks++;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Cycle 0 is the cycle in which start is high; done_cyc stays -1 on timeout.
  task automatic run_op(input logic [447:0] a, input int lat, input bit spam, input int budget,
                        output int done_cyc, output int ndone, output logic busy_at_done,
                        output logic [447:0] res);
    int cyc;
    fix_l = lat;
    acks  = 0;
    reqs  = 0;
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    cyc = 0;
    ndone = 0;
    done_cyc = -1;
    busy_at_done = 1'bx;
    while (cyc < budget && !(done_cyc >= 0 && cyc >= done_cyc + 4)) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          busy_at_done = busy;
        end
      end
      // With spam, start stays high through the DONE cycle and then drops.
      start = spam && (done_cyc < 0 || done_cyc == cyc);
      if (start) a_in = rand448();
    end
    start = 1'b0;
    res = result;
  endtask

  initial begin : main
    int           dc, nd, wait_cyc;
    logic         bd;
    logic [447:0] res, a, r0;

    p_w   = (449'd1 << 448) - (449'd1 << 224) - 449'd1;
    p     = p_w[447:0];
    r_one = (448'd1 << 224) + 448'd1;
    mont_two  = (448'd1 << 225) + 448'd2;
    mont_half = 448'd1 << 447;
    // R^-1 = 2^-448 mod p by repeated halving modulo p.
    p_w = 449'd1;
    for (int i = 0; i < 448; i++) p_w = p_w[0] ? ((p_w + {1'b0, p}) >> 1) : (p_w >> 1);
    rinv = p_w[447:0];

    fix_l = 0; acks = 0; reqs = 0; viol = 0; spur = 1'b0;
    rst = 1'b1; start = 1'b0; a_in = '0;
    #12;
    chk("rst_busy",    busy,    0);
    chk("rst_done",    done,    0);
    chk("rst_mul_req", mul_req, 0);
    chk("rst_result",  result,  0);
    chk("rst_mul_a",   mul_a,   0);
    chk("rst_mul_b",   mul_b,   0);
    @(negedge clk);
    rst = 1'b0;

    // Inverse of Montgomery one is itself.
    run_op(r_one, 0, 1'b0, 1200, dc, nd, bd, res);
    chk("one_done_cyc", dc, 893);
    chk("one_ndone",    nd, 1);
    chk("one_busy_at_done", bd, 0);
    chk("one_result",   res, r_one);
    chk("one_acks",     acks, 892);

    // Inverse of 2 is (p+1)/2, whose Montgomery form is 2^447.
    run_op(mont_two, 3, 1'b0, 4000, dc, nd, bd, res);
    chk("two_done_cyc", dc, 3569);
    chk("two_result",   res, mont_half);
    chk("two_product",  mont(res, mont_two), r_one);
    chk("two_reqs",     reqs, 892);

    // Random operands with random multiplier delay.
    for (int k = 0; k < 8; k++) begin
      a = rand448();
      run_op(a, -1, 1'b0, 8000, dc, nd, bd, res);
      chk($sformatf("rnd%0d_ndone", k), nd, 1);
      chk($sformatf("rnd%0d_product", k), mont(a, res), r_one);
    end
    chk("operand_stable", viol, 0);

    // Spurious ack while idle, then start spammed throughout an operation.
    r0 = result;
    spur = 1'b1;
    repeat (3) @(negedge clk);
    chk("spur_busy",   busy,   0);
    chk("spur_result", result, r0);
    run_op(mont_two, 1, 1'b1, 2200, dc, nd, bd, res);
    chk("spam_done_cyc", dc, 1785);
    chk("spam_ndone",    nd, 1);
    chk("spam_result",   res, mont_half);

    // Async reset while request 400 is in flight.
    fix_l = 5; acks = 0; reqs = 0;
    @(negedge clk);
    start = 1'b1;
    a_in  = rand448();
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (reqs < 400 && wait_cyc < 5000) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("rst_mid_reached", reqs, 400);
    rst = 1'b1;
    #1;
    chk("rst_mid_mul_req", mul_req, 0);
    chk("rst_mid_busy",    busy,    0);
    chk("rst_mid_result",  result,  0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(mont_two, 0, 1'b0, 1200, dc, nd, bd, res);
    chk("post_rst_done_cyc", dc, 893);
    chk("post_rst_result",   res, mont_half);

    // Zero operand.
`ifdef MONT_INV_ZERO_DET_EN
    run_op(448'd0, 0, 1'b0, 50, dc, nd, bd, res);
    chk("zero_done_cyc", dc, 2);
    chk("zero_err",      zero_err, 1);
    chk("zero_reqs",     reqs, 0);
    chk("zero_result",   res, 0);
`else
    run_op(448'd0, 0, 1'b0, 1200, dc, nd, bd, res);
    chk("zero_done_cyc", dc, 893);
    chk("zero_reqs",     reqs, 892);
    chk("zero_result",   res, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
